// File: rtl/fp_result_checker.sv
// -----------------------------------------------------------------------------
// fp_result_checker
// In-order result scoreboard placed directly downstream of fp_unit. Every
// issued operation pushes its expected result/flags (plus whether the quiet-NaN
// relaxation applies) into a FIFO. Each fp_unit ready pulse is compared against
// the FIFO head. The first failure is latched with its cause and data. Once the
// stimulus is exhausted and the FIFO has drained, the checker reports PASS.
//
// Ports
//   clock            single clock, all state on rising edge
//   reset            synchronous active-high reset
//   exp_valid        operation issued this cycle; push expected entry
//   exp_result       expected result
//   exp_flags        expected flags
//   exp_opcode       one-hot opcode of the issued op (bit6 fcmp, bit9 fcvt_f2i)
//   exp_ready        FIFO not full
//   calc_ready       fp_unit result valid
//   calc_result      fp_unit result
//   calc_flags       fp_unit flags
//   done             level; stimulus exhausted
//   pass_count       number of matched results
//   fail             sticky failure
//   fail_cause       0 none, 1 mismatch, 2 unexpected result, 3 overflow,
//                    4 timeout
//   fail_expected    expected result of the failing entry
//   fail_calc        calculated result of the failing entry
//   fail_result_diff result difference of the failing entry
//   fail_flags_diff  flags difference of the failing entry
//   finished         high in PASS or FAIL
// -----------------------------------------------------------------------------
module fp_result_checker #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exp_valid,
   input  logic [31:0] exp_result,
   input  logic [4:0]  exp_flags,
   input  logic [9:0]  exp_opcode,
   output logic        exp_ready,
   input  logic        calc_ready,
   input  logic [31:0] calc_result,
   input  logic [4:0]  calc_flags,
   input  logic        done,
   output logic [31:0] pass_count,
   output logic        fail,
   output logic [2:0]  fail_cause,
   output logic [31:0] fail_expected,
   output logic [31:0] fail_calc,
   output logic [31:0] fail_result_diff,
   output logic [4:0]  fail_flags_diff,
   output logic        finished
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PASS, ST_FAIL} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [31:0]   pass_count_q, pass_count_d;
   logic [2:0]    fail_cause_q, fail_cause_d;
   logic [31:0]   fail_expected_q, fail_expected_d;
   logic [31:0]   fail_calc_q, fail_calc_d;
   logic [31:0]   fail_rdiff_q, fail_rdiff_d;
   logic [4:0]    fail_fdiff_q, fail_fdiff_d;

   // Expected-entry storage. nan_mem holds whether the quiet-NaN relaxation
   // is allowed for the entry (neither fcmp nor fcvt_f2i).
   logic [31:0]   res_mem [DEPTH];
   logic [4:0]    flg_mem [DEPTH];
   logic          nan_mem [DEPTH];

   logic          unused_opcode_bits;
   assign unused_opcode_bits = ^{exp_opcode[8:7], exp_opcode[5:0]};

   logic        active, empty, full;
   logic        push, pop, unexpected, mismatch, overflow, to_hit;
   logic [31:0] head_res;
   logic [4:0]  head_flg;
   logic        head_nan_ok;
   logic [31:0] rdiff;
   logic [4:0]  fdiff;

   assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign head_res    = res_mem[rd_ptr_q];
   assign head_flg    = flg_mem[rd_ptr_q];
   assign head_nan_ok = nan_mem[rd_ptr_q];

   // A canonical quiet NaN from the unit only has to agree with the expected
   // value on exponent and quiet bit; the payload is free.
   assign rdiff = (head_nan_ok && (calc_result == 32'h7FC0_0000))
                ? {1'b0, calc_result[30:22] ^ head_res[30:22], 22'b0}
                : (calc_result ^ head_res);
   assign fdiff = calc_flags ^ head_flg;

   assign pop        = active && calc_ready && !empty;
   assign unexpected = active && calc_ready && empty;
   assign mismatch   = pop && ((rdiff != '0) || (fdiff != '0));
   // Push into a full FIFO is legal when the head leaves in the same cycle.
   assign push       = active && exp_valid && (!full || pop);
   assign overflow   = active && exp_valid && full && !pop;
   assign to_hit     = active && !empty && !calc_ready
                     && (to_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      to_cnt_d        = to_cnt_q;
      pass_count_d    = pass_count_q;
      fail_cause_d    = fail_cause_q;
      fail_expected_d = fail_expected_q;
      fail_calc_d     = fail_calc_q;
      fail_rdiff_d    = fail_rdiff_q;
      fail_fdiff_d    = fail_fdiff_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (active) begin
         to_cnt_d = (!empty && !calc_ready) ? to_cnt_q + TW'(1) : '0;
      end

      if (pop && !mismatch) pass_count_d = pass_count_q + 32'd1;

      case (state_q)
         ST_RUN:   if (done) state_d = ST_DRAIN;
         ST_DRAIN: if (empty && !calc_ready) state_d = ST_PASS;
         default:  state_d = state_q;
      endcase

      // Error priority: compare errors, then overflow, then timeout.
      if (mismatch) begin
         state_d         = ST_FAIL;
         fail_cause_d    = 3'd1;
         fail_expected_d = head_res;
         fail_calc_d     = calc_result;
         fail_rdiff_d    = rdiff;
         fail_fdiff_d    = fdiff;
      end else if (unexpected) begin
         state_d         = ST_FAIL;
         fail_cause_d    = 3'd2;
         fail_expected_d = '0;
         fail_calc_d     = calc_result;
         fail_rdiff_d    = '0;
         fail_fdiff_d    = '0;
      end else if (overflow || to_hit) begin
         state_d         = ST_FAIL;
         fail_cause_d    = overflow ? 3'd3 : 3'd4;
         fail_expected_d = '0;
         fail_calc_d     = '0;
         fail_rdiff_d    = '0;
         fail_fdiff_d    = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_RUN;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         to_cnt_q        <= '0;
         pass_count_q    <= '0;
         fail_cause_q    <= '0;
         fail_expected_q <= '0;
         fail_calc_q     <= '0;
         fail_rdiff_q    <= '0;
         fail_fdiff_q    <= '0;
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         to_cnt_q        <= to_cnt_d;
         pass_count_q    <= pass_count_d;
         fail_cause_q    <= fail_cause_d;
         fail_expected_q <= fail_expected_d;
         fail_calc_q     <= fail_calc_d;
         fail_rdiff_q    <= fail_rdiff_d;
         fail_fdiff_q    <= fail_fdiff_d;
      end
   end

   // Storage needs no reset: entries are only read when count says valid.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         res_mem[wr_ptr_q] <= exp_result;
         flg_mem[wr_ptr_q] <= exp_flags;
         nan_mem[wr_ptr_q] <= !(exp_opcode[9] || exp_opcode[6]);
      end
   end

   assign exp_ready        = !full;
   assign pass_count       = pass_count_q;
   assign fail             = (state_q == ST_FAIL);
   assign finished         = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign fail_cause       = fail_cause_q;
   assign fail_expected    = fail_expected_q;
   assign fail_calc        = fail_calc_q;
   assign fail_result_diff = fail_rdiff_q;
   assign fail_flags_diff  = fail_fdiff_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// -----------------------------------------------------------------------------
// tb_fp_result_checker
// Directed bench for fp_result_checker. Stimulus pushes the expected DUT event
// (pass_count step or failure report) into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever pass_count changes or fail rises.
// Static state (reset values, exp_ready, finished) is checked inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_result_checker;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 1024;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_result = '0;
   logic [4:0]  exp_flags = '0;
   logic [9:0]  exp_opcode = '0;
   logic        exp_ready;
   logic        calc_ready = 1'b0;
   logic [31:0] calc_result = '0;
   logic [4:0]  calc_flags = '0;
   logic        done = 1'b0;
   logic [31:0] pass_count;
   logic        fail;
   logic [2:0]  fail_cause;
   logic [31:0] fail_expected;
   logic [31:0] fail_calc;
   logic [31:0] fail_result_diff;
   logic [4:0]  fail_flags_diff;
   logic        finished;

   fp_result_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock            (clock),
      .reset            (reset),
      .exp_valid        (exp_valid),
      .exp_result       (exp_result),
      .exp_flags        (exp_flags),
      .exp_opcode       (exp_opcode),
      .exp_ready        (exp_ready),
      .calc_ready       (calc_ready),
      .calc_result      (calc_result),
      .calc_flags       (calc_flags),
      .done             (done),
      .pass_count       (pass_count),
      .fail             (fail),
      .fail_cause       (fail_cause),
      .fail_expected    (fail_expected),
      .fail_calc        (fail_calc),
      .fail_result_diff (fail_result_diff),
      .fail_flags_diff  (fail_flags_diff),
      .finished         (finished)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          is_fail;
      bit [31:0]   pc;
      bit [2:0]    cause;
      bit [31:0]   fexp;
      bit [31:0]   fcalc;
      bit [31:0]   rdiff;
      bit [4:0]    fdiff;
   } ev_t;

   ev_t         sb_q[$];
   int          checks = 0;
   int          errors = 0;
   bit [31:0]   model_pc = 0;
   int          txn = 0;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic exp_pass();
      ev_t e;
      model_pc = model_pc + 1;
      e.is_fail = 1'b0; e.pc = model_pc; e.cause = '0;
      e.fexp = '0; e.fcalc = '0; e.rdiff = '0; e.fdiff = '0;
      sb_q.push_back(e);
   endtask

   task automatic exp_fail(input bit [2:0] cause, input bit [31:0] fexp,
                           input bit [31:0] fcalc, input bit [31:0] rdiff,
                           input bit [4:0] fdiff);
      ev_t e;
      e.is_fail = 1'b1; e.pc = model_pc; e.cause = cause;
      e.fexp = fexp; e.fcalc = fcalc; e.rdiff = rdiff; e.fdiff = fdiff;
      sb_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   bit [31:0] prev_pc;
   bit        prev_fail;

   always @(negedge clock) begin
      if (reset) begin
         prev_pc   = pass_count;
         prev_fail = fail;
      end else begin
         if ((pass_count != prev_pc) || (fail && !prev_fail)) begin
            txn++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event actual pass_count=%0d fail=%0b required=no event",
                        pass_count, fail);
            end else begin
               ev_t e;
               e = sb_q.pop_front();
               if (e.is_fail) begin
                  check32("mon_fail", {31'b0, fail}, 32'd1);
                  check32("mon_fail_cause", {29'b0, fail_cause}, {29'b0, e.cause});
                  check32("mon_fail_expected", fail_expected, e.fexp);
                  check32("mon_fail_calc", fail_calc, e.fcalc);
                  check32("mon_fail_result_diff", fail_result_diff, e.rdiff);
                  check32("mon_fail_flags_diff", {27'b0, fail_flags_diff}, {27'b0, e.fdiff});
                  check32("mon_pass_count_frozen", pass_count, e.pc);
                  $display("txn %0d fail cause=%0d expected=0x%08h calc=0x%08h",
                           txn, fail_cause, fail_expected, fail_calc);
               end else begin
                  check32("mon_pass_count", pass_count, e.pc);
                  check32("mon_no_fail", {31'b0, fail}, 32'd0);
                  $display("txn %0d match pass_count=%0d", txn, pass_count);
               end
            end
         end
         prev_pc   = pass_count;
         prev_fail = fail;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input bit v, input bit [31:0] r, input bit [4:0] f,
                       input bit [9:0] o, input bit cr, input bit [31:0] cres,
                       input bit [4:0] cf);
      exp_valid   = v;
      exp_result  = r;
      exp_flags   = f;
      exp_opcode  = o;
      calc_ready  = cr;
      calc_result = cres;
      calc_flags  = cf;
      tick();
      exp_valid   = 1'b0;
      calc_ready  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_drained(input string name);
      check32(name, sb_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      exp_valid = 1'b0; calc_ready = 1'b0; done = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_pc = 0;
      sb_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      do_reset();
      check32("rst_exp_ready", {31'b0, exp_ready}, 32'd1);
      check32("rst_pass_count", pass_count, 32'd0);
      check32("rst_fail", {31'b0, fail}, 32'd0);
      check32("rst_fail_cause", {29'b0, fail_cause}, 32'd0);
      check32("rst_finished", {31'b0, finished}, 32'd0);

      // ---- three vectors, variable latency 2/5/9 ----
      step(1, 32'h3F80_0000, 5'h00, 10'h002, 0, 0, 0);            // c0
      step(1, 32'h4000_0000, 5'h01, 10'h002, 0, 0, 0);            // c1
      exp_pass();
      step(1, 32'h7FC0_0000, 5'h10, 10'h002, 1, 32'h3F80_0000, 5'h00); // c2
      idle(3);                                                    // c3-c5
      exp_pass();
      step(0, 0, 0, 0, 1, 32'h4000_0000, 5'h01);                  // c6
      idle(4);                                                    // c7-c10
      exp_pass();
      step(0, 0, 0, 0, 1, 32'h7FC0_0000, 5'h10);                  // c11
      done = 1'b1;
      idle(3);
      check32("t1_pass_count", pass_count, 32'd3);
      check32("t1_finished", {31'b0, finished}, 32'd1);
      check32("t1_fail", {31'b0, fail}, 32'd0);
      check_drained("t1_drained");

      // ---- quiet-NaN relaxation ----
      do_reset();
      step(1, 32'h7FC0_0001, 5'h10, 10'h002, 0, 0, 0);
      exp_pass();
      step(0, 0, 0, 0, 1, 32'h7FC0_0000, 5'h10);
      idle(1);
      check32("t2_nan_match_fail", {31'b0, fail}, 32'd0);
      step(1, 32'h7FC0_0001, 5'h10, 10'h040, 0, 0, 0);
      exp_fail(3'd1, 32'h7FC0_0001, 32'h7FC0_0000, 32'h0000_0001, 5'h00);
      step(0, 0, 0, 0, 1, 32'h7FC0_0000, 5'h10);
      idle(2);
      check32("t2_finished", {31'b0, finished}, 32'd1);
      check32("t2_pass_count", pass_count, 32'd1);
      check_drained("t2_drained");

      // ---- flags mismatch ----
      do_reset();
      step(1, 32'h3F80_0000, 5'h00, 10'h002, 0, 0, 0);
      exp_fail(3'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 5'h01);
      step(0, 0, 0, 0, 1, 32'h3F80_0000, 5'h01);
      idle(2);
      check_drained("t3_drained");

      // ---- full FIFO, push+pop while full, then overflow ----
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         step(1, 32'h4000_0000 + i, 5'h00, 10'h002, 0, 0, 0);
      check32("t4_exp_ready_full", {31'b0, exp_ready}, 32'd0);
      exp_pass();
      step(1, 32'h5000_0000, 5'h00, 10'h002, 1, 32'h4000_0000, 5'h00);
      idle(1);
      check32("t4_still_full", {31'b0, exp_ready}, 32'd0);
      check32("t4_no_fail", {31'b0, fail}, 32'd0);
      exp_fail(3'd3, 0, 0, 0, 0);
      step(1, 32'h5000_0001, 5'h00, 10'h002, 0, 0, 0);
      idle(2);
      check32("t4_finished", {31'b0, finished}, 32'd1);
      check_drained("t4_drained");

      // ---- unexpected result, no bypass ----
      do_reset();
      exp_fail(3'd2, 0, 32'hDEAD_BEEF, 0, 0);
      step(1, 32'hDEAD_BEEF, 5'h00, 10'h002, 1, 32'hDEAD_BEEF, 5'h00);
      idle(2);
      check_drained("t5_drained");

      // ---- timeout boundary ----
      do_reset();
      step(1, 32'h3F80_0000, 5'h00, 10'h002, 0, 0, 0);
      idle(TIMEOUT - 1);
      check32("t6_no_timeout_yet", {31'b0, fail}, 32'd0);
      exp_fail(3'd4, 0, 0, 0, 0);
      idle(1);
      idle(1);
      check32("t6_timeout_fail", {31'b0, fail}, 32'd1);
      check_drained("t6_drained");

      // ---- reset mid-run with entries queued ----
      do_reset();
      step(1, 32'h3F80_0000, 5'h00, 10'h002, 0, 0, 0);
      exp_pass();
      step(0, 0, 0, 0, 1, 32'h3F80_0000, 5'h00);
      for (int i = 0; i < 4; i++)
         step(1, 32'h4100_0000 + i, 5'h00, 10'h002, 0, 0, 0);
      check32("t7_pre_reset_count", pass_count, 32'd1);
      check_drained("t7_pre_reset_drained");
      do_reset();
      check32("t7_exp_ready", {31'b0, exp_ready}, 32'd1);
      check32("t7_pass_count", pass_count, 32'd0);
      check32("t7_fail", {31'b0, fail}, 32'd0);
      step(1, 32'h4040_0000, 5'h00, 10'h002, 0, 0, 0);
      exp_pass();
      step(0, 0, 0, 0, 1, 32'h4040_0000, 5'h00);
      done = 1'b1;
      idle(3);
      check32("t7_finished", {31'b0, finished}, 32'd1);
      check32("t7_final_fail", {31'b0, fail}, 32'd0);
      check32("t7_final_count", pass_count, 32'd1);
      check_drained("t7_drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
